// File: rtl/maze_session_if.sv
// Handshake bundle between the maze session controller and its driver/solver side.
interface maze_session_if;
    logic       go;
    logic       solver_done;
    logic       solver_fail;
    logic       solver_move;
    logic       solver_start;
    logic       solver_run;
    logic       busy;
    logic       success;
    logic       failed;
    logic       timeout;
    logic [7:0] move_count;

    modport master (
        output go, solver_done, solver_fail, solver_move,
        input  solver_start, solver_run, busy, success, failed, timeout, move_count
    );

    modport slave (
        input  go, solver_done, solver_fail, solver_move,
        output solver_start, solver_run, busy, success, failed, timeout, move_count
    );
endinterface

// File: rtl/maze_session_ctrl.sv
// Maze session controller: starts the solver, kicks the replay and counts replayed moves.
// Define MAZE_SESSION_TIMEOUT_EN to add a per-phase watchdog (limit TIMEOUT_CYCLES).
module maze_session_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd40000
) (
    input  logic          clk,
    input  logic          rst,
    maze_session_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SOLVE,
        S_KICK,
        S_REPLAY
    } state_e;

    state_e     state_q;
    logic       start_q;
    logic       run_q;
    logic       busy_q;
    logic       success_q;
    logic       failed_q;
    logic       first_q;
    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       replay_done;
    logic       wd_trip;

    assign count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    // Replay completes only on a done without a move, and never in its first cycle.
    assign replay_done = bus.solver_done & ~bus.solver_move & ~first_q;

`ifdef MAZE_SESSION_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        timeout_q;
    logic        in_phase;
    logic        phase_exit;

    assign in_phase = (state_q == S_SOLVE) || (state_q == S_REPLAY);

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        phase_exit = 1'b0;
        if (state_q == S_SOLVE) begin
            phase_exit = bus.solver_fail | bus.solver_done;
        end else if (state_q == S_REPLAY) begin
            phase_exit = bus.solver_fail | replay_done;
        end
    end

    // Expiry loses to a genuine phase exit in the same cycle.
    assign wd_trip = in_phase && (wd_q == TIMEOUT_CYCLES - 16'd1) && !phase_exit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (in_phase) begin
                wd_q <= wd_q + 16'd1;
            end else begin
                wd_q <= '0;
            end
            if (state_q == S_IDLE && bus.go) begin
                timeout_q <= 1'b0;
            end else if (wd_trip) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    logic [15:0] unused_timeout_cycles;

    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_trip               = 1'b0;
    assign bus.timeout           = 1'b0;
`endif

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            success_q <= 1'b0;
            failed_q  <= 1'b0;
            first_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            start_q <= 1'b0;
            run_q   <= 1'b0;
            first_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.go) begin
                        state_q   <= S_LAUNCH;
                        start_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        success_q <= 1'b0;
                        failed_q  <= 1'b0;
                        count_q   <= '0;
                    end
                end
                S_LAUNCH: state_q <= S_SOLVE;
                S_SOLVE: begin
                    if (bus.solver_fail || wd_trip) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        failed_q <= 1'b1;
                    end else if (bus.solver_done) begin
                        state_q <= S_KICK;
                        run_q   <= 1'b1;
                    end
                end
                S_KICK: begin
                    state_q <= S_REPLAY;
                    first_q <= 1'b1;
                end
                S_REPLAY: begin
                    if (bus.solver_move && !bus.solver_fail) begin
                        count_q <= count_d;
                    end
                    if (bus.solver_fail || wd_trip) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        failed_q <= 1'b1;
                    end else if (replay_done) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        success_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.solver_start = start_q;
    assign bus.solver_run   = run_q;
    assign bus.busy         = busy_q;
    assign bus.success      = success_q;
    assign bus.failed       = failed_q;
    assign bus.move_count   = count_q;
endmodule

// File: tb/tb_maze_session_ctrl.sv
// Bench for maze_session_ctrl: session vector table, directed corner sequences,
// and random sessions scored against a session-level reference model.
module tb_maze_session_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   start_cnt = 0;
    int   run_cnt = 0;

    maze_session_if bus ();
    maze_session_if bus_wd ();

    maze_session_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Second instance with a short watchdog, fed the same solver inputs.
    maze_session_ctrl #(.TIMEOUT_CYCLES(16'd100)) dut_wd (
        .clk (clk),
        .rst (rst),
        .bus (bus_wd)
    );

    assign bus_wd.go          = bus.go;
    assign bus_wd.solver_done = bus.solver_done;
    assign bus_wd.solver_fail = bus.solver_fail;
    assign bus_wd.solver_move = bus.solver_move;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.solver_start === 1'b1) start_cnt++;
        if (bus.solver_run === 1'b1) run_cnt++;
    end

    typedef struct packed {
        logic done;
        logic fail;
        logic move;
    } cyc_t;

    typedef struct {
        int   solve_wait;
        logic s_done;
        logic s_fail;
        int   n_moves;
        logic early_done;
        logic overlap;
        logic r_fail;
        logic e_success;
        logic e_failed;
        int   e_count;
        int   e_runs;
    } vec_t;

    typedef struct {
        logic success;
        logic failed;
        int   count;
        int   runs;
    } exp_t;

    cyc_t solve_q[$];
    cyc_t replay_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic d, input logic f, input logic m);
        cyc_t c;
        c.done = d;
        c.fail = f;
        c.move = m;
        return c;
    endfunction

    task automatic drive(input cyc_t c);
        bus.solver_done = c.done;
        bus.solver_fail = c.fail;
        bus.solver_move = c.move;
    endtask

    // Session outcome from the scripted solver behaviour, rule by rule.
    function automatic exp_t model();
        exp_t e;
        int   k;
        e.success = 1'b0;
        e.failed  = 1'b0;
        e.count   = 0;
        e.runs    = 0;
        k = 0;
        while (k < solve_q.size() && !solve_q[k].done && !solve_q[k].fail) k++;
        if (k == solve_q.size()) return e;
        if (solve_q[k].fail) begin
            e.failed = 1'b1;
            return e;
        end
        e.runs = 1;
        for (int j = 0; j < replay_q.size(); j++) begin
            if (replay_q[j].fail) begin
                e.failed = 1'b1;
                break;
            end
            if (replay_q[j].move) e.count = (e.count < 255) ? e.count + 1 : 255;
            if (replay_q[j].done && !replay_q[j].move && j > 0) begin
                e.success = 1'b1;
                break;
            end
        end
        return e;
    endfunction

    task automatic wait_start(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.solver_start === 1'b1);
        end
        check({tag, "_start_seen"}, 32'(seen), 1);
    endtask

    task automatic run_session(input string tag);
        cyc_t last;
        start_cnt = 0;
        run_cnt   = 0;
        @(posedge clk); #1;
        bus.go = 1'b1;
        wait_start(tag);
        bus.go = 1'b0;
        foreach (solve_q[i]) begin
            @(posedge clk); #1;
            drive(solve_q[i]);
        end
        last = solve_q[solve_q.size() - 1];
        if (last.done && !last.fail) begin
            @(posedge clk); #1;
            drive(mk(1'b0, 1'b0, 1'b0));
            foreach (replay_q[i]) begin
                @(posedge clk); #1;
                drive(replay_q[i]);
            end
        end
        @(negedge clk);
        check({tag, "_busy_before_end"}, 32'(bus.busy), 1);
        @(posedge clk); #1;
        drive(mk(1'b0, 1'b0, 1'b0));
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_success"}, 32'(bus.success), 32'(e.success));
        check({tag, "_failed"}, 32'(bus.failed), 32'(e.failed));
        check({tag, "_excl"}, 32'(bus.success & bus.failed), 0);
        check({tag, "_timeout"}, 32'(bus.timeout), 0);
        check({tag, "_count"}, 32'(bus.move_count), e.count);
        check({tag, "_starts"}, start_cnt, 1);
        check({tag, "_runs"}, run_cnt, e.runs);
    endtask

    task automatic build_from_vec(input vec_t v);
        solve_q.delete();
        replay_q.delete();
        for (int i = 0; i < v.solve_wait; i++) solve_q.push_back(mk(1'b0, 1'b0, 1'b1));
        solve_q.push_back(mk(v.s_done, v.s_fail, 1'b0));
        if (v.early_done) replay_q.push_back(mk(1'b1, 1'b0, 1'b0));
        for (int i = 0; i < v.n_moves; i++)
            replay_q.push_back(mk(v.overlap && (i == v.n_moves - 1), 1'b0, 1'b1));
        replay_q.push_back(v.r_fail ? mk(1'b0, 1'b1, 1'b0) : mk(1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   sl;
        int   rl;
        logic mv;
        logic dn;

        // wait, s_done, s_fail, moves, early_done, overlap, r_fail | success, failed, count, runs
        vecs[0] = '{4, 1'b1, 1'b0, 7,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7,   1};
        vecs[1] = '{2, 1'b1, 1'b1, 3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0};
        vecs[2] = '{0, 1'b0, 1'b1, 0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0,   0};
        vecs[3] = '{1, 1'b1, 1'b0, 300, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 255, 1};
        vecs[4] = '{3, 1'b1, 1'b0, 5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5,   1};
        vecs[5] = '{2, 1'b1, 1'b0, 3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3,   1};
        vecs[6] = '{0, 1'b1, 1'b0, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0,   1};
        vecs[7] = '{1, 1'b1, 1'b0, 255, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 255, 1};

        bus.go = 1'b0;
        drive(mk(1'b0, 1'b0, 1'b0));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_flags", {29'd0, bus.success, bus.failed, bus.timeout}, 0);
        check("rst_count", 32'(bus.move_count), 0);
        check("rst_pulses", {30'd0, bus.solver_start, bus.solver_run}, 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            exp_t ev;
            ev.success = vecs[i].e_success;
            ev.failed  = vecs[i].e_failed;
            ev.count   = vecs[i].e_count;
            ev.runs    = vecs[i].e_runs;
            build_from_vec(vecs[i]);
            run_session($sformatf("vec%0d", i));
            check_result($sformatf("vec%0d", i), ev);
        end

        // go held high across two sessions; relaunch on the cycle after IDLE entry
        start_cnt = 0;
        @(posedge clk); #1;
        bus.go = 1'b1;
        wait_start("hold");
        @(posedge clk); #1;
        bus.solver_fail = 1'b1;
        @(posedge clk); #1;
        bus.solver_fail = 1'b0;
        @(negedge clk);
        check("hold_idle_busy", 32'(bus.busy), 0);
        check("hold_idle_failed", 32'(bus.failed), 1);
        @(negedge clk);
        check("hold_relaunch", 32'(bus.solver_start), 1);
        check("hold_relaunch_failed_clr", 32'(bus.failed), 0);
        bus.go = 1'b0;
        @(posedge clk); #1;
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        @(posedge clk); #1;
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        repeat (2) @(negedge clk);
        check("go_ignored_starts", start_cnt, 2);
        check("go_ignored_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        bus.solver_fail = 1'b1;
        @(posedge clk); #1;
        bus.solver_fail = 1'b0;
        @(negedge clk);
        check("hold_end_busy", 32'(bus.busy), 0);

        // Asynchronous reset in the middle of REPLAY
        start_cnt = 0;
        @(posedge clk); #1;
        bus.go = 1'b1;
        wait_start("mid");
        bus.go = 1'b0;
        @(posedge clk); #1;
        drive(mk(1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        drive(mk(1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        drive(mk(1'b0, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive(mk(1'b0, 1'b0, 1'b1));
        @(posedge clk); #3;
        check("mid_pre_count", 32'(bus.move_count), 2);
        check("mid_pre_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_count", 32'(bus.move_count), 0);
        check("mid_rst_flags", {29'd0, bus.success, bus.failed, bus.timeout}, 0);
        check("mid_rst_pulses", {30'd0, bus.solver_start, bus.solver_run}, 0);
        drive(mk(1'b0, 1'b0, 1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_after_busy", 32'(bus.busy), 0);
        check("mid_after_starts", start_cnt, 1);

        // Silent solver against the 100-cycle watchdog instance
        @(posedge clk); #1;
        bus.go = 1'b1;
        wait_start("wd");
        bus.go = 1'b0;
        @(posedge clk);
        repeat (99) @(posedge clk);
        @(negedge clk);
        check("wd_busy_99", 32'(bus_wd.busy), 1);
        @(posedge clk);
        @(negedge clk);
`ifdef MAZE_SESSION_TIMEOUT_EN
        check("wd_busy_100", 32'(bus_wd.busy), 0);
        check("wd_failed", 32'(bus_wd.failed), 1);
        check("wd_timeout", 32'(bus_wd.timeout), 1);
        check("wd_success", 32'(bus_wd.success), 0);
`else
        check("wd_busy_100", 32'(bus_wd.busy), 1);
        check("wd_timeout", 32'(bus_wd.timeout), 0);
`endif
        check("wd_main_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        bus.solver_fail = 1'b1;
        @(posedge clk); #1;
        bus.solver_fail = 1'b0;
        @(negedge clk);
        check("wd_end_busy", 32'(bus.busy | bus_wd.busy), 0);

        // Random sessions scored against the model, then a hold check under input noise
        for (int s = 0; s < 30; s++) begin
            sl = int'($urandom_range(0, 15));
            rl = int'($urandom_range(1, 40));
            solve_q.delete();
            replay_q.delete();
            for (int i = 0; i < sl; i++) solve_q.push_back(mk(1'b0, 1'b0, 1'($urandom_range(0, 1))));
            case ($urandom_range(0, 3))
                0:       solve_q.push_back(mk(1'b0, 1'b1, 1'($urandom_range(0, 1))));
                1:       solve_q.push_back(mk(1'b1, 1'b1, 1'($urandom_range(0, 1))));
                default: solve_q.push_back(mk(1'b1, 1'b0, 1'($urandom_range(0, 1))));
            endcase
            for (int j = 0; j < rl; j++) begin
                mv = 1'($urandom_range(0, 1));
                dn = ($urandom_range(0, 3) == 0);
                if (dn && j > 0) mv = 1'b1;
                replay_q.push_back(mk(dn, 1'b0, mv));
            end
            if ($urandom_range(0, 4) == 0) replay_q.push_back(mk(1'b0, 1'b1, 1'($urandom_range(0, 1))));
            else replay_q.push_back(mk(1'b1, 1'b0, 1'b0));
            e = model();
            run_session($sformatf("rnd%0d", s));
            check_result($sformatf("rnd%0d", s), e);
            repeat (2) begin
                @(posedge clk); #1;
                drive(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
            end
            @(posedge clk); #1;
            drive(mk(1'b0, 1'b0, 1'b0));
            @(negedge clk);
            check($sformatf("rnd%0d_hold_success", s), 32'(bus.success), 32'(e.success));
            check($sformatf("rnd%0d_hold_count", s), 32'(bus.move_count), e.count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/maze_session_ctrl.md
MAZE_SESSION_CTRL -- requirements
Module: maze_session_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd40000: watchdog limit in cycles per phase (SOLVE, REPLAY).
REQ-002 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  session request, level, sampled in IDLE.
- solver_done  in  1  solver phase-complete flag.
- solver_fail  in  1  solver no-path flag.
- solver_move  in  1  solver one-cycle move pulse.
- solver_start  out  1  start pulse to solver.
- solver_run  out  1  replay launch pulse to solver.
- busy  out  1  session in progress.
- success  out  1  last session solved and replayed.
- failed  out  1  last session ended in failure or timeout.
- timeout  out  1  last session ended by watchdog.
- move_count  out  8  move pulses counted in last replay.

Function
REQ-004 The FSM SHALL have states IDLE, LAUNCH, SOLVE, KICK, REPLAY; all outputs SHALL be registered.
REQ-005 IDLE: go=1 SHALL move to LAUNCH, clear success/failed/timeout/move_count and set busy on that edge; otherwise stay.
REQ-006 LAUNCH SHALL drive solver_start=1 for exactly one cycle, then move to SOLVE.
REQ-007 SOLVE: solver_fail=1 SHALL move to IDLE with failed=1; else solver_done=1 SHALL move to KICK; else stay.
REQ-008 In SOLVE, simultaneous solver_done and solver_fail SHALL resolve to failure.
REQ-009 In SOLVE, solver_move pulses SHALL be ignored and move_count SHALL stay 0.
REQ-010 KICK SHALL drive solver_run=1 for exactly one cycle, then move to REPLAY.
REQ-011 REPLAY: each cycle with solver_move=1 SHALL increment move_count, saturating at 8'd255.
REQ-012 REPLAY: solver_done SHALL be ignored in the first REPLAY cycle.
REQ-013 REPLAY: after the first cycle, solver_done=1 with solver_move=0 SHALL move to IDLE with success=1.
REQ-014 REPLAY: solver_done=1 with solver_move=1 in the same cycle SHALL count the move, stay in REPLAY, and complete on the next done-without-move cycle.
REQ-015 REPLAY: solver_fail=1 SHALL move to IDLE with failed=1; move_count SHALL hold its value.
REQ-016 busy SHALL be 1 in every non-IDLE state and drop on the same edge that enters IDLE.
REQ-017 go SHALL be ignored while busy; go held high SHALL start a new session on the first IDLE cycle.
REQ-018 success, failed, timeout and move_count SHALL hold until the next accepted go.
REQ-019 success and failed SHALL never be 1 together.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE and set all outputs to 0, including move_count and the watchdog counter.
REQ-021 Reset mid-session SHALL abort the session with no status reported; solver_start/solver_run SHALL NOT pulse during reset.

Configuration
REQ-022 Macro MAZE_SESSION_TIMEOUT_EN defined: a 16-bit watchdog SHALL clear on entering SOLVE and on entering REPLAY, and increment each cycle in those states.
REQ-023 With the macro defined, when the count reaches TIMEOUT_CYCLES-1 without a phase exit, the FSM SHALL enter IDLE with failed=1 and timeout=1.
REQ-024 With the macro defined, a phase exit and expiry in the same cycle SHALL resolve to the phase exit.
REQ-025 Macro not defined: no watchdog logic; timeout SHALL be constant 0; SOLVE and REPLAY SHALL wait indefinitely.

Verification
REQ-026 Reset: rst pulse mid-REPLAY -> busy=0, move_count=0, all flags 0 immediately, with no clock edge needed.
REQ-027 Success path: go=1; solver_done 5 cycles after solver_start; 7 move pulses; then done -> exactly one solver_start pulse, exactly one solver_run pulse, success=1, move_count=7.
REQ-028 Solve failure: solver_fail and solver_done high in the same SOLVE cycle -> failed=1, success=0, solver_run never asserted.
REQ-029 Saturation and overlap: 300 move pulses, then done coincident with a move, then done alone -> move_count=255, success=1 one cycle after the lone done.
REQ-030 Busy/go: go held high across two sessions -> second LAUNCH in the cycle after the first IDLE entry; go pulses during SOLVE ignored.
REQ-031 Timeout (MAZE_SESSION_TIMEOUT_EN, TIMEOUT_CYCLES=100): solver silent after start -> failed=1, timeout=1, busy drops 100 cycles after SOLVE entry; without the macro busy stays 1.
